// File: rtl/booth_mult_sched_pkg.sv
// Shared types for booth_mult_sched: FSM state encoding and the Booth
// recoding values seen on {Q[0], Q_1}.
package booth_mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } booth_state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_mult_sched_step.sv
// booth_step: one combinational radix-2 Booth step followed by the
// arithmetic right shift of {A, Q, Q_1}.
module booth_step
  import booth_mult_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q1_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q1_o
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  always_comb begin
    // One guard bit keeps A - M exact when M is the most negative value.
    m_ext = {m_i[WIDTH-1], m_i};
    case ({q_i[0], q1_i})
      BOOTH_ADD: sum = a_i + m_ext;
      BOOTH_SUB: sum = a_i - m_ext;
      default:   sum = a_i;
    endcase
    a_o  = {sum[WIDTH], sum[WIDTH:1]};
    q_o  = {sum[0], q_i[WIDTH-1:1]};
    q1_o = q_i[0];
  end

endmodule

// File: rtl/booth_mult_sched.sv
// Sequential radix-2 Booth multiplier shared by NREQ requesters.
// Define BOOTH_MULT_SCHED_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module booth_mult_sched
  import booth_mult_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_multiplier,
  input  logic [NREQ*WIDTH-1:0] req_multiplicand,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_product,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  booth_state_t       state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH:0]     a_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic               q1_nxt;

  logic               grant_vld;
  logic [IDW-1:0]     grant_idx;
  logic [IDW-1:0]     grant_inc;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i  (a_q),
    .q_i  (q_q),
    .q1_i (q1_q),
    .m_i  (m_q),
    .a_o  (a_nxt),
    .q_o  (q_nxt),
    .q1_o (q1_nxt)
  );

`ifdef BOOTH_MULT_SCHED_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  // Scan from the pointer with wrap; the descending loop lets the
  // lowest offset overwrite any later match.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req_valid[(int'(ptr_q) + off) % NREQ]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'((int'(ptr_q) + off) % NREQ);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && grant_vld) begin
      ptr_d = grant_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(i);
      end
    end
  end
`endif

  assign grant_inc = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          m_d     = req_multiplier[grant_idx*WIDTH +: WIDTH];
          a_d     = '0;
          q_d     = req_multiplicand[grant_idx*WIDTH +: WIDTH];
          q1_d    = 1'b0;
          cnt_d   = '0;
          id_d    = grant_idx;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_nxt;
        q_d   = q_nxt;
        q1_d  = q1_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          prod_d  = {a_nxt[WIDTH-1:0], q_nxt};
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      id_q    <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      prod_q  <= prod_d;
    end
  end

  assign rsp_valid   = (state_q == DONE);
  assign rsp_product = prod_q;
  assign rsp_id      = id_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_booth_mult_sched.sv
// Self-checking bench for booth_mult_sched (WIDTH=8, NREQ=2): directed
// vector table, backpressure, mid-RUN reset, contention and a short random run.
module tb_booth_mult_sched;

  localparam int WIDTH = 8;
  localparam int NREQ  = 2;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_multiplier;
  logic [15:0] req_multiplicand;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_product;
  logic [0:0]  rsp_id;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  booth_mult_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_multiplier   (req_multiplier),
    .req_multiplicand (req_multiplicand),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_product      (rsp_product),
    .rsp_id           (rsp_id),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  valid;
    logic [7:0]  m0, q0, m1, q1;
    logic [1:0]  rdy;
    logic [15:0] prod;
    logic        id;
    int          stall;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the block in IDLE; returns at a negedge in IDLE.
  task automatic run_op(input string tag, input logic [1:0] valid,
                        input logic [7:0] m0, input logic [7:0] q0,
                        input logic [7:0] m1, input logic [7:0] q1,
                        input logic [1:0] exp_rdy, input logic [15:0] exp_prod,
                        input logic exp_id, input int stall);
    int n;
    req_valid        = valid;
    req_multiplier   = {m1, m0};
    req_multiplicand = {q1, q0};
    rsp_ready        = (stall == 0);
    #1;
    chk({tag, " req_ready"}, 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    chk({tag, " busy_run"}, 32'(busy), 32'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 32'(n), 32'(WIDTH));
    chk({tag, " product"}, 32'(rsp_product), 32'(exp_prod));
    chk({tag, " id"}, 32'(rsp_id), 32'(exp_id));
    for (int s = 0; s < stall; s++) begin
      req_valid = 2'b11;
      @(posedge clk);
      @(negedge clk);
      chk({tag, " stall valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " stall product"}, 32'(rsp_product), 32'(exp_prod));
      chk({tag, " stall id"}, 32'(rsp_id), 32'(exp_id));
      chk({tag, " stall req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, " stall busy"}, 32'(busy), 32'd1);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0]  rm, rq;
    logic [15:0] rp;
    int          r, n, last_cyc;
    logic        exp_ids[4];

    vecs[0] = '{2'b01, 8'd7,   8'hFD, 8'h00, 8'h00, 2'b01, 16'hFFEB, 1'b0, 5};
    vecs[1] = '{2'b01, 8'h80,  8'h80, 8'h00, 8'h00, 2'b01, 16'h4000, 1'b0, 0};
    vecs[2] = '{2'b01, 8'h80,  8'h7F, 8'h00, 8'h00, 2'b01, 16'hC080, 1'b0, 2};
    vecs[3] = '{2'b01, 8'h00,  8'hFF, 8'h00, 8'h00, 2'b01, 16'h0000, 1'b0, 0};
    vecs[4] = '{2'b10, 8'h00,  8'h00, 8'd5,  8'd6,  2'b10, 16'h001E, 1'b1, 0};
    vecs[5] = '{2'b10, 8'h00,  8'h00, 8'h7F, 8'h7F, 2'b10, 16'h3F01, 1'b1, 1};
    vecs[6] = '{2'b11, 8'd3,   8'hFC, 8'd9,  8'd9,  2'b01, 16'hFFF4, 1'b0, 0};
`ifdef BOOTH_MULT_SCHED_ROUND_ROBIN_EN
    vecs[7] = '{2'b11, 8'd2,   8'd3,  8'hFF, 8'hFF, 2'b10, 16'h0001, 1'b1, 0};
`else
    vecs[7] = '{2'b11, 8'd2,   8'd3,  8'hFF, 8'hFF, 2'b01, 16'h0006, 1'b0, 0};
`endif
    vecs[8] = '{2'b01, 8'hFF,  8'h01, 8'h00, 8'h00, 2'b01, 16'hFFFF, 1'b0, 0};
    vecs[9] = '{2'b01, 8'hFF,  8'h80, 8'h00, 8'h00, 2'b01, 16'h0080, 1'b0, 0};

    rst              = 1'b1;
    req_valid        = 2'b11;
    req_multiplier   = 16'h0305;
    req_multiplicand = 16'h0407;
    rsp_ready        = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_product", 32'(rsp_product), 32'd0);
    chk("reset rsp_id", 32'(rsp_id), 32'd0);
    req_valid = 2'b00;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].valid, vecs[i].m0, vecs[i].q0,
             vecs[i].m1, vecs[i].q1, vecs[i].rdy, vecs[i].prod, vecs[i].id,
             vecs[i].stall);
    end

    // Abort an operation after its third Booth step.
    req_valid        = 2'b01;
    req_multiplier   = {8'd0, 8'd7};
    req_multiplicand = {8'd0, 8'hFD};
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrun busy before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrun busy", 32'(busy), 32'd0);
    chk("midrun rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrun req_ready", 32'(req_ready), 32'd0);
    chk("midrun rsp_product", 32'(rsp_product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_reset", 2'b11, 8'd7, 8'hFD, 8'd4, 8'd4, 2'b01, 16'hFFEB, 1'b0, 0);

    // Contention from a clean pointer with both requesters always valid.
    pulse_reset();
`ifdef BOOTH_MULT_SCHED_ROUND_ROBIN_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    req_multiplier   = {8'd3, 8'd2};
    req_multiplicand = {8'd3, 8'd2};
    rsp_ready        = 1'b1;
    req_valid        = 2'b11;
    last_cyc         = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!rsp_valid && n < 30) begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
      chk($sformatf("contend%0d valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("contend%0d id", k), 32'(rsp_id), 32'(exp_ids[k]));
      chk($sformatf("contend%0d product", k), 32'(rsp_product),
          exp_ids[k] ? 32'h0009 : 32'h0004);
      if (k > 0) chk($sformatf("contend%0d spacing", k), 32'(cyc - last_cyc), 32'(WIDTH + 2));
      last_cyc = cyc;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 2'b00;
    @(negedge clk);
    while (busy) @(negedge clk);

    // Short random regression against a signed-multiply reference.
    for (int k = 0; k < 200; k++) begin
      r  = $urandom_range(0, 1);
      rm = 8'($urandom);
      rq = 8'($urandom);
      rp = 16'($signed(rm) * $signed(rq));
      if (r == 0)
        run_op($sformatf("rand%0d", k), 2'b01, rm, rq, 8'h00, 8'h00, 2'b01, rp, 1'b0,
               int'($urandom_range(0, 3)));
      else
        run_op($sformatf("rand%0d", k), 2'b10, 8'h00, 8'h00, rm, rq, 2'b10, rp, 1'b1,
               int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/booth_mult_sched.md
# booth_mult_sched

Sequential radix-2 Booth multiplier shared between `NREQ` requesters. It holds one Booth step datapath and iterates it once per clock for `WIDTH` cycles per operation. A round-robin arbiter sits in front, and a valid/ready response port carries the product and the requester ID. The block sits where several pipeline agents need a signed product but the area budget allows only one multiplier.

## Interface
- `WIDTH`, default 8: operand width in bits, signed two's complement, ≥ 2.
- `NREQ`, default 2: number of requesters, ≥ 1; `IDW = max(1, $clog2(NREQ))`.
- `clk`  input  1  clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `req_valid`  input  NREQ  request valid, bit i = requester i.
- `req_ready`  output  NREQ  request accepted when valid & ready.
- `req_multiplier`  input  NREQ*WIDTH  M operand, slice i = requester i.
- `req_multiplicand`  input  NREQ*WIDTH  Q operand, slice i = requester i.
- `rsp_valid`  output  1  product available.
- `rsp_ready`  input  1  consumer takes product.
- `rsp_product`  output  2*WIDTH  signed product M×Q.
- `rsp_id`  output  IDW  index of requester that issued the operation.
- `busy`  output  1  high in RUN and DONE.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - The arbiter picks one requester from `req_valid`.
  - `req_ready` is one-hot on the granted bit and zero otherwise, so it depends combinationally on `req_valid`.
  - On handshake the block latches:
    - M from the granted slice
    - A = 0 (WIDTH+1 bits)
    - Q = multiplicand
    - Q_1 = 0
    - step counter = 0
    - `rsp_id` = grant index
  - It then moves to RUN.
- **RUN**
  - Each cycle looks at {Q[0], Q_1}:
    - 01: A ← A + M
    - 10: A ← A − M
    - 00/11: A unchanged
  - After that, {A, Q, Q_1} shifts arithmetically right by 1.
  - The counter increments. After the WIDTH-th step the FSM moves to DONE.
- **Arithmetic width rule:** the accumulator is WIDTH+1 bits, with M sign-extended. This makes M = −2^(WIDTH−1) exact. The product is {A[WIDTH−1:0], Q}.
- **DONE**
  - `rsp_valid` = 1.
  - `rsp_product` and `rsp_id` stay stable until `rsp_ready`.
  - On handshake the FSM returns to IDLE.
- **Arbitration:** round-robin. The pointer advances to grant index + 1, mod NREQ, on every accepted request. The requester at the pointer has top priority, then the others in ascending index order with wrap.
- No request is accepted in RUN or DONE; `req_ready` = 0 in those states.
- **Reset (any time, including mid-RUN):** the operation is aborted and the FSM returns to IDLE. Reset values:
  - `rsp_valid` = 0, `rsp_product` = 0, `rsp_id` = 0, `busy` = 0, `req_ready` = 0
  - RR pointer = 0, counter = 0

## Timing
- Request accepted at edge k. Booth steps are applied on edges k+1 … k+WIDTH, and `rsp_valid` rises after edge k+WIDTH.
- Latency from accept edge to `rsp_valid` is WIDTH cycles.
- If `rsp_ready` is held high, DONE lasts one cycle and the FSM is in IDLE after edge k+WIDTH+1. The next accept happens at that edge+1, so peak throughput is one product per WIDTH+2 cycles.
- If `rsp_ready` is low, DONE holds indefinitely, and all `req_ready` stay 0.
- `rsp_product` only updates on the transition into DONE. While in RUN it shows the previous product.

## Configuration
- Macro: `BOOTH_MULT_SCHED_ROUND_ROBIN_EN`.
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority, where the lowest index wins. The RR pointer register is not built.

## Structure
- Package `booth_mult_sched_pkg` holds:
  - the state enum `booth_state_t` (IDLE, RUN, DONE)
  - the Booth select encodings (`BOOTH_ADD` = 2'b01, `BOOTH_SUB` = 2'b10)
- Sub-module `booth_step`: a combinational single radix-2 Booth step.
  - Inputs: A (WIDTH+1), Q, Q_1, M.
  - Outputs: next A, next Q, next Q_1.
  - The top level instantiates it once and registers its outputs.

## Test plan
- Single op, WIDTH = 8: requester 0 sends M = 7, Q = −3. `req_ready[0]` is high in the same cycle; `rsp_valid` rises 8 cycles after accept with `rsp_product` = 16'hFFEB (−21) and `rsp_id` = 0.
- Corner operands: M = −128 with Q = −128 gives 16'h4000; M = −128 with Q = 127 gives 16'hC080; M = 0 with Q = −1 gives 16'h0000.
- Contention:
  - With the macro defined, both `req_valid` are held high with distinct operands: grants alternate 0, 1, 0, 1 and `rsp_id` follows the same order.
  - With the macro undefined, requester 0 always wins.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles in DONE. `rsp_product` and `rsp_id` must stay stable, `req_ready` must stay 0, and `busy` must stay 1. Raising `rsp_ready` returns the FSM to IDLE on the next edge.
- Reset mid-RUN: assert `rst` after step 3. `busy`, `rsp_valid` and `req_ready` go to 0 immediately. After release, a fresh request completes with the correct product, and requester 0 has priority.
- Random regression: 10k random signed operand pairs from random requesters with random `rsp_ready` stalls. Every product must equal the reference product, and responses must arrive in accept order.
